inst_fetcher: RTL

//  Front-end producer for the decoder's if_to_dc_* interface. Holds the PC and fetches one

---
 rtl/inst_fetcher.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetcher.sv
// inst_fetcher: single-outstanding instruction fetch with predecode, static branch prediction and flush redirect
package inst_fetcher_pkg;
   typedef enum logic [2:0] {OP_RC, OP_RI, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_U} op_type_e;
   typedef enum logic [5:0] {
      E_NOP, E_LUI, E_AUIPC, E_JAL, E_JALR, E_BEQ, E_BNE, E_BLT, E_BGE, E_BLTU, E_BGEU,
      E_LB, E_LH, E_LW, E_LBU, E_LHU, E_SB, E_SH, E_SW,
      E_ADDI, E_SLTI, E_SLTIU, E_XORI, E_ORI, E_ANDI, E_SLLI, E_SRLI, E_SRAI,
      E_ADD, E_SUB, E_SLL, E_SLT, E_SLTU, E_XOR, E_OR, E_AND, E_SRL, E_SRA
   } op_e;
endpackage

module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        if_to_mc_req,
   output logic [31:0] if_to_mc_addr,
   input  logic        mc_to_if_valid,
   input  logic [31:0] mc_to_if_inst,
   input  logic        stall_in,
   input  logic        rob_flush,
   input  logic [31:0] rob_target_pc,
   output logic        if_to_dc_ready,
   output logic [31:0] if_to_dc_PC,
   output logic [31:0] if_to_dc_inst,
   output op_e         if_to_dc_op,
   output op_type_e    if_to_dc_opType,
   output logic        if_to_dc_pred_jump
);
   typedef enum logic [1:0] {FETCH, HOLD, DELIVER, DRAIN} state_e;
   state_e      state;
   logic [31:0] pc, imm_b, imm_j, nxt_pc;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic        f7, take;
   op_e         dec_op;
   op_type_e    cls, dec_type;
   assign opc = mc_to_if_inst[6:0];
   assign f3 = mc_to_if_inst[14:12];
   assign f7 = mc_to_if_inst[30];
   assign imm_b = {{20{mc_to_if_inst[31]}}, mc_to_if_inst[7], mc_to_if_inst[30:25], mc_to_if_inst[11:8], 1'b0};
   assign imm_j = {{12{mc_to_if_inst[31]}}, mc_to_if_inst[19:12], mc_to_if_inst[20], mc_to_if_inst[30:21], 1'b0};
   always_comb begin
      dec_op = E_NOP;
      cls = OP_RI;
      case (opc)
         7'b0110011: begin
            cls = OP_RC;
            case (f3)
               3'd0: dec_op = f7 ? E_SUB : E_ADD;
               3'd1: dec_op = E_SLL;
               3'd2: dec_op = E_SLT;
               3'd3: dec_op = E_SLTU;
               3'd4: dec_op = E_XOR;
               3'd5: dec_op = f7 ? E_SRA : E_SRL;
               3'd6: dec_op = E_OR;
               3'd7: dec_op = E_AND;
            endcase
         end
         7'b0010011:
            case (f3)
               3'd0: dec_op = E_ADDI;
               3'd1: dec_op = E_SLLI;
               3'd2: dec_op = E_SLTI;
               3'd3: dec_op = E_SLTIU;
               3'd4: dec_op = E_XORI;
               3'd5: dec_op = f7 ? E_SRAI : E_SRLI;
               3'd6: dec_op = E_ORI;
               3'd7: dec_op = E_ANDI;
            endcase
         7'b0000011: begin
            cls = OP_LD;
            case (f3)
               3'd0: dec_op = E_LB;
               3'd1: dec_op = E_LH;
               3'd2: dec_op = E_LW;
               3'd4: dec_op = E_LBU;
               3'd5: dec_op = E_LHU;
               default: ;
            endcase
         end
         7'b0100011: begin
            cls = OP_ST;
            dec_op = f3 == 3'd0 ? E_SB : f3 == 3'd1 ? E_SH : f3 == 3'd2 ? E_SW : E_NOP;
         end
         7'b1100011: begin
            cls = OP_BR;
            case (f3)
               3'd0: dec_op = E_BEQ;
               3'd1: dec_op = E_BNE;
               3'd4: dec_op = E_BLT;
               3'd5: dec_op = E_BGE;
               3'd6: dec_op = E_BLTU;
               3'd7: dec_op = E_BGEU;
               default: ;
            endcase
         end
         7'b1101111: begin
            cls = OP_JAL;
            dec_op = E_JAL;
         end
         7'b1100111: begin
            cls = OP_JALR;
            dec_op = f3 == 3'd0 ? E_JALR : E_NOP;
         end
         7'b0110111: begin
            cls = OP_U;
            dec_op = E_LUI;
         end
         7'b0010111: begin
            cls = OP_U;
            dec_op = E_AUIPC;
         end
         default: ;
      endcase
      // Unrecognised encodings travel down the pipe as a harmless immediate-class NOP
      dec_type = dec_op == E_NOP ? OP_RI : cls;
   end
   assign take = dec_type == OP_JAL || (dec_type == OP_BR && imm_b[31]);
   assign nxt_pc = pc + (dec_type == OP_JAL ? imm_j : take ? imm_b : 32'd4);
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= FETCH;
         pc <= RESET_PC;
         if_to_dc_PC <= '0;
         if_to_dc_inst <= '0;
         if_to_dc_op <= E_NOP;
         if_to_dc_opType <= OP_RC;
         if_to_dc_pred_jump <= 1'b0;
      end else if (rdy_in) begin
         if (rob_flush) begin
            pc <= rob_target_pc;
            if_to_dc_pred_jump <= 1'b0;
            // An unanswered request must have its late response swallowed
            state <= (state == DRAIN || (state == FETCH && !mc_to_if_valid)) ? DRAIN : FETCH;
         end else begin
            case (state)
               FETCH:
                  if (mc_to_if_valid) begin
                     if_to_dc_PC <= pc;
                     if_to_dc_inst <= mc_to_if_inst;
                     if_to_dc_op <= dec_op;
                     if_to_dc_opType <= dec_type;
                     if_to_dc_pred_jump <= take;
                     pc <= nxt_pc;
                     state <= stall_in ? HOLD : DELIVER;
                  end
               HOLD: if (!stall_in) state <= DELIVER;
               DELIVER: state <= FETCH;
               DRAIN: if (mc_to_if_valid) state <= FETCH;
            endcase
         end
      end
   end
   assign if_to_mc_req = state == FETCH && !rst_in;
   assign if_to_mc_addr = pc;
   assign if_to_dc_ready = state == DELIVER && !rob_flush;
endmodule
